hdmi_video_timing_ctrl: RTL

Video timing controller that sequences the HDMI TX datapath.
- Generates hsync/vsync/de for the TMDS encoder.
- Schedules the HDMI video preamble (CTL code) and the 2-character video guard band before every active line.
- Issues a one-cycle-ahead pixel request with coordinates to the pixel source.
- Sits in the pixel clock domain, directly upstream of the encoder/serializer top.

---
 rtl/hdmi_timing_pkg.sv | 37 +++
 rtl/timing_axis_counter.sv | 67 ++++++
 rtl/hdmi_video_timing_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared types and constants for the HDMI video timing controller and its axis counters.
package hdmi_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACT,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } t_phase;

    localparam int unsigned CNT_W = 12;

    localparam logic [3:0] CTL_IDLE           = 4'b0000;
    localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned GUARD_LEN    = 2;

    // Encoder-facing control bundle; delayed as a unit between the two pipeline stages.
    typedef struct packed {
        logic       de;
        logic       hsync;
        logic       vsync;
        logic [3:0] ctrl;
        logic       guard;
        logic       line_start;
        logic       frame_start;
    } t_video_ctl;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One timing axis: a wrapping position counter with its ACT/FRONT/SYNC/BACK phase tracked
// as a registered state alongside it.
module timing_axis_counter
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48
) (
    input  logic             pixclk_i,
    input  logic             reset_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output t_phase           phase_o,
    output logic             wrap_o
);

    localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

    if (TOTAL > 4095) begin : g_total_chk
        $error("timing_axis_counter: total %0d does not fit the 12-bit counter", TOTAL);
    end
    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_len_chk
        $error("timing_axis_counter: every phase needs a length of at least 1");
    end

    logic [CNT_W-1:0] count_q, count_d;
    t_phase           phase_q, phase_d;

    always_ff @(posedge pixclk_i) begin
        if (reset_i) begin
            count_q <= '0;
            phase_q <= PH_ACT;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            // Phase advances on the last count of the current phase, so it stays aligned with count_q.
            case (phase_q)
                PH_ACT:   if (count_q == END_ACT)  phase_d = PH_FRONT;
                PH_FRONT: if (count_q == END_FP)   phase_d = PH_SYNC;
                PH_SYNC:  if (count_q == END_SYNC) phase_d = PH_BACK;
                PH_BACK:  if (count_q == LAST)     phase_d = PH_ACT;
                default:  phase_d = PH_ACT;
            endcase
        end
    end

    // Terminal count: the counter wraps on the next enabled cycle.
    assign wrap_o  = (count_q == LAST);
    assign count_o = count_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/hdmi_video_timing_ctrl.sv
// HDMI TX video timing: sync/DE generation, video preamble and guard band scheduling,
// and a one-cycle-ahead pixel request to the pixel source.
module hdmi_video_timing_ctrl
    import hdmi_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter bit          HDMI_MODE  = 1'b1
) (
    input  logic        i_pixclk,
    input  logic        i_reset,
    output logic        o_pix_req,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [3:0]  o_ctrl,
    output logic        o_guard,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);

    localparam logic [CNT_W-1:0] PRE_START   = CNT_W'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
    localparam logic [CNT_W-1:0] GUARD_START = CNT_W'(H_TOTAL - GUARD_LEN);
    localparam logic [CNT_W-1:0] V_ACT_LINES = CNT_W'(V_ACTIVE);

    localparam t_video_ctl CTL_RESET = '{
        de:          1'b0,
        hsync:       ~H_SYNC_POL,
        vsync:       ~V_SYNC_POL,
        ctrl:        CTL_IDLE,
        guard:       1'b0,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    if (HDMI_MODE && H_BP < PREAMBLE_LEN + GUARD_LEN) begin : g_bp_chk
        $error("hdmi_video_timing_ctrl: H_BP %0d too short for preamble and guard band", H_BP);
    end

    logic [CNT_W-1:0] h_cnt, v_cnt;
    t_phase           h_phase, v_phase;
    logic             h_wrap, v_wrap;

    timing_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .pixclk_i (i_pixclk),
        .reset_i  (i_reset),
        .en_i     (1'b1),
        .count_o  (h_cnt),
        .phase_o  (h_phase),
        .wrap_o   (h_wrap)
    );

    timing_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .pixclk_i (i_pixclk),
        .reset_i  (i_reset),
        .en_i     (h_wrap),
        .count_o  (v_cnt),
        .phase_o  (v_phase),
        .wrap_o   (v_wrap)
    );

    logic             pix_req_q, pix_req_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    t_video_ctl       ctl_s1_q, ctl_s1_d;
    t_video_ctl       ctl_s2_q;
    logic             active;
    logic             next_line_active;

    always_comb begin
        active = (h_phase == PH_ACT) && (v_phase == PH_ACT);
        // Line after the last frame line is line 0, which is always active.
        next_line_active = v_wrap ? 1'b1 : ((v_cnt + 1'b1) < V_ACT_LINES);

        pix_req_d = active;
        x_d       = h_cnt;
        y_d       = v_cnt;

        ctl_s1_d             = CTL_RESET;
        ctl_s1_d.de          = active;
        ctl_s1_d.hsync       = (h_phase == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
        ctl_s1_d.vsync       = (v_phase == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
        ctl_s1_d.line_start  = active && (h_cnt == '0);
        ctl_s1_d.frame_start = active && (h_cnt == '0) && (v_cnt == '0);

        if (HDMI_MODE && next_line_active) begin
            if (h_cnt >= GUARD_START) begin
                ctl_s1_d.guard = 1'b1;
            end else if (h_cnt >= PRE_START) begin
                ctl_s1_d.ctrl = CTL_VIDEO_PREAMBLE;
            end
        end
    end

    // Stage 1 carries the request; stage 2 delays the control bundle so DE meets the returned pixel.
    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            pix_req_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            ctl_s1_q  <= CTL_RESET;
            ctl_s2_q  <= CTL_RESET;
        end else begin
            pix_req_q <= pix_req_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ctl_s1_q  <= ctl_s1_d;
            ctl_s2_q  <= ctl_s1_q;
        end
    end

    assign o_pix_req     = pix_req_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_de          = ctl_s2_q.de;
    assign o_hsync       = ctl_s2_q.hsync;
    assign o_vsync       = ctl_s2_q.vsync;
    assign o_ctrl        = ctl_s2_q.ctrl;
    assign o_guard       = ctl_s2_q.guard;
    assign o_line_start  = ctl_s2_q.line_start;
    assign o_frame_start = ctl_s2_q.frame_start;

endmodule
